// File: rtl/ucie_ctl_sb_cfg_tx.sv
// ucie_ctl_sb_cfg_tx
//   Sideband transmit stage between the adapter sideband encoder and the RDI
//   lp_cfg bus. Complete sideband messages (64-bit header plus optional 64-bit
//   data) are buffered in a small FIFO and serialized onto o_rdi_lp_cfg in
//   NC-bit beats, LSB chunk first. A message may only start when at least one
//   RDI credit is available. Credits come back as i_rdi_pl_cfg_crd pulses.
//
// Parameters
//   NC       lp_cfg width (16, 32 or 64); BEATS = 64/NC beats per 64-bit word
//   DEPTH    message FIFO entries (power of 2, >= 2)
//   MAX_CRD  credits granted at reset; also the credit ceiling
//   CW       credit counter width (2**CW > MAX_CRD)
//
// Ports
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_msg_vld/o_msg_rdy  message write handshake
//   i_msg_hdr            sideband header
//   i_msg_has_data       a data phase follows the header
//   i_msg_data           data phase (ignored when i_msg_has_data=0)
//   i_rdi_pl_cfg_crd     one-cycle credit return pulse
//   o_rdi_lp_cfg_vld     beat valid
//   o_rdi_lp_cfg         beat payload
//   o_crd_avail          current credit count
//   o_sb_tx_busy         FIFO non-empty or serializer active
//   o_crd_overflow       sticky: credit returned while the count was full
//
// Handshake: a message is written at the rising edge where i_msg_vld and
// o_msg_rdy are both high. A write presented while o_msg_rdy=0 is dropped.
// The lp_cfg side has no backpressure: once a message starts, its beats are
// driven on consecutive cycles with o_rdi_lp_cfg_vld=1.
//
// Build option
//   UCIE_CTL_SB_TX_PARITY_EN  when defined, header bit 62 (CP) and bit 63 (DP)
//                             are replaced by computed parity at pop time.

module ucie_ctl_sb_cfg_tx #(
  parameter int NC      = 32,
  parameter int DEPTH   = 4,
  parameter int MAX_CRD = 32,
  parameter int CW      = 6
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_msg_vld,
  input  logic [63:0]   i_msg_hdr,
  input  logic          i_msg_has_data,
  input  logic [63:0]   i_msg_data,
  output logic          o_msg_rdy,
  input  logic          i_rdi_pl_cfg_crd,
  output logic          o_rdi_lp_cfg_vld,
  output logic [NC-1:0] o_rdi_lp_cfg,
  output logic [CW-1:0] o_crd_avail,
  output logic          o_sb_tx_busy,
  output logic          o_crd_overflow
);

  localparam int BEATS = 64 / NC;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // ---------------------------------------------------------------- FIFO
  logic [63:0]   mem_hdr  [DEPTH];
  logic [63:0]   mem_data [DEPTH];
  logic          mem_hd   [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;

  logic fifo_full, fifo_empty, push, pop;

  // ---------------------------------------------------------------- FSM / credits
  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [127:0]  sr_q, sr_d;
  logic          has_data_q, has_data_d;
  logic          vld_q, vld_d;
  logic [NC-1:0] cfg_q, cfg_d;
  logic [CW-1:0] crd_q, crd_d;
  logic          ovf_q, ovf_d;

  logic [63:0]   head_hdr, head_data, hdr_tx;
  logic          head_hd;
  logic          crd_full;

  assign fifo_full  = (cnt_q == (AW+1)'(DEPTH));
  assign fifo_empty = (cnt_q == '0);
  assign push       = i_msg_vld && !fifo_full;
  assign pop        = (state_q == ST_IDLE) && !fifo_empty && (crd_q != '0);
  assign crd_full   = (crd_q == CW'(MAX_CRD));

  assign head_hdr   = mem_hdr[rd_ptr_q];
  assign head_data  = mem_data[rd_ptr_q];
  assign head_hd    = mem_hd[rd_ptr_q];

  // Header as it goes on the wire; parity bits are filled in only when the
  // option is built in, otherwise the header is passed through untouched.
  always_comb begin
    hdr_tx = head_hdr;
`ifdef UCIE_CTL_SB_TX_PARITY_EN
    hdr_tx[62] = ^head_hdr[61:0];
    hdr_tx[63] = head_hd ? ^head_data : 1'b0;
`endif
  end

  // FIFO pointer / occupancy next-state
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Serializer next-state. The output registers are loaded with the beat that
  // belongs to the next state, so the first beat is visible the cycle after
  // the pop edge and the last-beat cycle is always followed by one IDLE cycle.
  // sr_q holds the not-yet-sent chunks, header first then data, LSB first.
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    sr_d       = sr_q;
    has_data_d = has_data_q;
    vld_d      = 1'b0;
    cfg_d      = cfg_q;
    case (state_q)
      ST_IDLE: begin
        if (pop) begin
          sr_d       = {head_data, hdr_tx} >> NC;
          cfg_d      = hdr_tx[NC-1:0];
          vld_d      = 1'b1;
          bcnt_d     = '0;
          has_data_d = head_hd;
          state_d    = ST_HDR;
        end
      end
      ST_HDR: begin
        if (bcnt_q == BW'(BEATS-1)) begin
          if (has_data_q) begin
            cfg_d   = sr_q[NC-1:0];
            sr_d    = sr_q >> NC;
            vld_d   = 1'b1;
            bcnt_d  = '0;
            state_d = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cfg_d  = sr_q[NC-1:0];
          sr_d   = sr_q >> NC;
          vld_d  = 1'b1;
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      ST_DATA: begin
        if (bcnt_q == BW'(BEATS-1)) begin
          state_d = ST_IDLE;
        end else begin
          cfg_d  = sr_q[NC-1:0];
          sr_d   = sr_q >> NC;
          vld_d  = 1'b1;
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Credit counter. A pop and a return in the same cycle cancel out; a return
  // at the ceiling is swallowed and flagged.
  always_comb begin
    crd_d = crd_q;
    ovf_d = ovf_q;
    case ({pop, i_rdi_pl_cfg_crd})
      2'b10: crd_d = crd_q - CW'(1);
      2'b01: begin
        if (crd_full) ovf_d = 1'b1;
        else          crd_d = crd_q + CW'(1);
      end
      default: crd_d = crd_q;
    endcase
  end

  // Message storage has no reset: only the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_hdr[wr_ptr_q]  <= i_msg_hdr;
      mem_data[wr_ptr_q] <= i_msg_data;
      mem_hd[wr_ptr_q]   <= i_msg_has_data;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      crd_q    <= CW'(MAX_CRD);
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      crd_q    <= crd_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      bcnt_q     <= '0;
      sr_q       <= '0;
      has_data_q <= 1'b0;
      vld_q      <= 1'b0;
      cfg_q      <= '0;
    end else begin
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      sr_q       <= sr_d;
      has_data_q <= has_data_d;
      vld_q      <= vld_d;
      cfg_q      <= cfg_d;
    end
  end

  assign o_msg_rdy        = !fifo_full;
  assign o_rdi_lp_cfg_vld = vld_q;
  assign o_rdi_lp_cfg     = cfg_q;
  assign o_crd_avail      = crd_q;
  assign o_crd_overflow   = ovf_q;
  assign o_sb_tx_busy     = !fifo_empty || (state_q != ST_IDLE);

endmodule
